// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte to the keyboard using inhibit, request-to-send, 8 data bits
// (LSB first), odd parity, a released stop bit and an ACK check, with a timeout.
// The ps2 lines are only ever pulled low through the *_oe outputs.
// Optional feature macro: PS2_HOST_TX_RETRY_EN.
// When it is defined, a NACK or timeout restarts the frame from inhibit, up to
// two times, before tx_error is reported.

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    // Synchroniser chains and edge detector for the device-driven lines.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    // Frame state.
    state_t        state,   state_n;
    logic [CW-1:0] cnt,     cnt_n;
    logic [TW-1:0] tmo,     tmo_n;
    logic [3:0]    n,       n_n;
    logic [7:0]    sh,      sh_n;
    logic          par,     par_n;
    logic          clk_oe_n;
    logic          data_oe_n;
    logic          done_n;
    logic          error_n;
    logic          failed;
    logic          timed_out;

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]    retry,   retry_n;
`endif

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~clk_s;
    assign timed_out = (tmo == TMO_LIMIT);
    assign tx_busy   = (state != S_IDLE);

    // Bring the raw ps2 lines into the system clock domain; idle level is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= ps2_clk_in;
            data_sync[0] <= ps2_data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_s;
        end
    end

    // Next-state logic: sequences the frame and decides the next line drive.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tmo_n     = tmo;
        n_n       = n;
        sh_n      = sh;
        par_n     = par;
        data_oe_n = 1'b0;
        done_n    = 1'b0;
        failed    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_n   = retry;
`endif

        unique case (state)
            S_IDLE: begin
                if (tx_start) begin
                    sh_n    = tx_data;
                    par_n   = ~^tx_data;
                    cnt_n   = '0;
                    tmo_n   = '0;
                    n_n     = '0;
                    state_n = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n   = S_RTS;
                    tmo_n     = TW'(1);
                    n_n       = '0;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_RTS: begin
                data_oe_n = ps2_data_oe;
                tmo_n     = tmo + TW'(1);
                if (timed_out) begin
                    tmo_n  = tmo;
                    failed = 1'b1;
                end else if (fall) begin
                    n_n = n + 4'd1;
                    if (n < 4'd8) begin
                        data_oe_n = ~sh[n[2:0]];
                    end else if (n == 4'd8) begin
                        data_oe_n = ~par;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = S_ACK;
                    end
                end
            end

            S_ACK: begin
                tmo_n = tmo + TW'(1);
                if (timed_out) begin
                    tmo_n  = tmo;
                    failed = 1'b1;
                end else if (fall) begin
                    if (!data_s) begin
                        state_n = S_WAIT_IDLE;
                    end else begin
                        failed = 1'b1;
                    end
                end
            end

            S_WAIT_IDLE: begin
                tmo_n = tmo + TW'(1);
                if (timed_out) begin
                    tmo_n  = tmo;
                    failed = 1'b1;
                end else if (clk_s && data_s) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end

            S_FAIL: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_RETRY_EN
        if (failed) begin
            if (retry < 2'd2) begin
                retry_n = retry + 2'd1;
                cnt_n   = '0;
                state_n = S_INHIBIT;
            end else begin
                state_n = S_FAIL;
            end
        end
        if (state_n == S_IDLE || state_n == S_FAIL) begin
            retry_n = '0;
        end
`else
        if (failed) begin
            state_n = S_FAIL;
        end
`endif

        if (state_n == S_INHIBIT) begin
            data_oe_n = (cnt_n == INH_LAST);
        end else if (state_n != S_RTS) begin
            data_oe_n = 1'b0;
        end

        clk_oe_n = (state_n == S_INHIBIT);
        error_n  = (state_n == S_FAIL);
    end

    // State register; outputs are registered so they line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tmo         <= '0;
            n           <= '0;
            sh          <= '0;
            par         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tmo         <= tmo_n;
            n           <= n_n;
            sh          <= sh_n;
            par         <= par_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_done     <= done_n;
            tx_error    <= error_n;
        end
    end

`ifdef PS2_HOST_TX_RETRY_EN
    // Attempt counter; cleared whenever a transfer finishes either way.
    always_ff @(posedge clock) begin
        if (reset) begin
            retry <= '0;
        end else begin
            retry <= retry_n;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a PS/2 device model.

module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       devClkLow;
    logic       devDataLow;
    logic       clkLine;
    logic       dataLine;

    int   total = 0;
    int   bad = 0;
    int   doneCount = 0;
    int   errCount = 0;
    int   inhStarts = 0;
    int   inhibitEnds = 0;
    int   inhLen = 0;
    int   inhDataCycles = 0;
    int   lastInhLen = 0;
    int   lastInhData = 0;
    int   sinceRelease = 0;
    logic prevOe = 1'b0;

    assign clkLine  = ~(ps2_clk_oe | devClkLow);
    assign dataLine = ~(ps2_data_oe | devDataLow);

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(clkLine),
        .ps2_data_in(dataLine),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Expected line levels seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] expectedFrame(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (($countones(b) % 2) == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n cycles, sampling at the falling system clock edge and tracking pulses and inhibit phases.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tx_done === 1'b1) doneCount++;
            if (tx_error === 1'b1) errCount++;
            if (tx_done === 1'b1 || tx_error === 1'b1)
                checkOutput("pulse_exclusive", 32'(tx_done & tx_error), 32'd0);
            if (ps2_clk_oe === 1'b1) begin
                if (!prevOe) begin
                    inhStarts++;
                    inhLen = 0;
                    inhDataCycles = 0;
                end
                inhLen++;
                if (ps2_data_oe === 1'b1) inhDataCycles++;
            end else if (prevOe) begin
                inhibitEnds++;
                sinceRelease = 0;
                lastInhLen = inhLen;
                lastInhData = inhDataCycles;
            end else begin
                sinceRelease++;
            end
            prevOe = (ps2_clk_oe === 1'b1);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tx_data = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        checkOutput("busy_after_start", 32'(tx_busy), 32'd1);
    endtask

    // Device side of one frame: waits for the inhibit to end, clocks 10 bits, then the ACK clock.
    task automatic runFrame(input bit ack, input int target, input int midStartBit, input int resetBit,
                            input logic [7:0] b, output logic [10:0] frame);
        int guard;
        guard = 0;
        frame = '0;
        while (inhibitEnds < target && guard < 1000) begin
            tick(1);
            guard++;
        end
        checkOutput("inhibit_end_seen", 32'(inhibitEnds >= target), 32'd1);
        if (inhibitEnds < target) return;
        tick(5);
        frame[0] = dataLine;
        for (int k = 1; k <= 10; k++) begin
            devClkLow = 1'b1;
            tick(15);
            if (k == resetBit) begin
                checkOutput("pre_reset_drive", 32'(ps2_data_oe), 32'(!b[k-1]));
                reset = 1'b1;
                tick(1);
                checkOutput("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
                checkOutput("reset_data_oe", 32'(ps2_data_oe), 32'd0);
                checkOutput("reset_busy", 32'(tx_busy), 32'd0);
                reset = 1'b0;
                devClkLow = 1'b0;
                tick(30);
                return;
            end
            if (k == midStartBit) begin
                tx_data = 8'h00;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
                tick(14);
            end else begin
                tick(15);
            end
            devClkLow = 1'b0;
            frame[k] = dataLine;
            tick(30);
        end
        if (ack) devDataLow = 1'b1;
        devClkLow = 1'b1;
        tick(30);
        devClkLow = 1'b0;
        tick(5);
        devDataLow = 1'b0;
        tick(40);
    endtask

    task automatic sendAndCheck(input logic [7:0] b, input int midStartBit);
        int d0;
        int e0;
        int target;
        logic [10:0] frame;
        d0 = doneCount;
        e0 = errCount;
        target = inhibitEnds + 1;
        applyStimulus(b);
        runFrame(1'b1, target, midStartBit, 0, b, frame);
        checkOutput("frame_bits", 32'(frame), 32'(expectedFrame(b)));
        checkOutput("inhibit_len", 32'(lastInhLen), 32'(INH));
        checkOutput("start_bit_cycles", 32'(lastInhData), 32'd1);
        checkOutput("done_pulses", 32'(doneCount - d0), 32'd1);
        checkOutput("error_pulses", 32'(errCount - e0), 32'd0);
        checkOutput("busy_after_done", 32'(tx_busy), 32'd0);
        checkOutput("clk_oe_idle", 32'(ps2_clk_oe), 32'd0);
        checkOutput("data_oe_idle", 32'(ps2_data_oe), 32'd0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [10:0] frame;
        int d0;
        int e0;
        int s0;
        int base;
        int guard;

        reset = 1'b1;
        tx_start = 1'b1;
        tx_data = 8'hF4;
        devClkLow = 1'b0;
        devDataLow = 1'b0;

        // Reset held with tx_start high: nothing may start.
        tick(5);
        checkOutput("rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("rst_done", 32'(tx_done), 32'd0);
        checkOutput("rst_error", 32'(tx_error), 32'd0);
        reset = 1'b0;
        tx_start = 1'b0;
        tick(50);
        checkOutput("post_rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("post_rst_no_inhibit", 32'(inhStarts), 32'd0);

        // Directed commands, then random bytes.
        sendAndCheck(8'hED, 0);
        sendAndCheck(8'hF4, 0);
        for (int r = 0; r < 3; r++) begin
            sendAndCheck(8'($urandom), 0);
        end

        // Device NACKs every attempt.
        b = 8'($urandom);
        d0 = doneCount;
        e0 = errCount;
        s0 = inhStarts;
        base = inhibitEnds;
        applyStimulus(b);
        for (int a = 1; a <= ATTEMPTS; a++) begin
            runFrame(1'b0, base + a, 0, 0, b, frame);
            checkOutput("nack_frame", 32'(frame), 32'(expectedFrame(b)));
            checkOutput("nack_errors_so_far", 32'(errCount - e0), 32'((a == ATTEMPTS) ? 1 : 0));
            checkOutput("nack_busy", 32'(tx_busy), 32'((a < ATTEMPTS) ? 1 : 0));
        end
        checkOutput("nack_no_done", 32'(doneCount - d0), 32'd0);
        checkOutput("nack_inhibits", 32'(inhStarts - s0), 32'(ATTEMPTS));

        // Device never clocks after request-to-send.
        b = 8'($urandom);
        d0 = doneCount;
        e0 = errCount;
        s0 = inhStarts;
        applyStimulus(b);
        guard = 0;
        while (errCount == e0 && guard < ATTEMPTS * (INH + TMO) + 500) begin
            tick(1);
            guard++;
        end
        checkOutput("timeout_error_seen", 32'(errCount - e0), 32'd1);
        checkOutput("timeout_cycles", 32'(sinceRelease), 32'(TMO));
        checkOutput("timeout_inhibits", 32'(inhStarts - s0), 32'(ATTEMPTS));
        tick(1);
        checkOutput("timeout_busy", 32'(tx_busy), 32'd0);
        checkOutput("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("timeout_no_done", 32'(doneCount - d0), 32'd0);

        // tx_start with 0x00 while busy is ignored.
        sendAndCheck(8'($urandom) | 8'h01, 3);

        // Reset at bit 4, then a clean 0xFF transfer.
        b = 8'($urandom) & 8'hF7;
        d0 = doneCount;
        e0 = errCount;
        s0 = inhStarts;
        applyStimulus(b);
        runFrame(1'b1, inhibitEnds + 1, 0, 4, b, frame);
        tick(100);
        checkOutput("reset_no_done", 32'(doneCount - d0), 32'd0);
        checkOutput("reset_no_error", 32'(errCount - e0), 32'd0);
        checkOutput("reset_idle_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_no_restart", 32'(inhStarts - s0), 32'd1);
        sendAndCheck(8'hFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
